// File: rtl/cmp_pkg.sv
// Shared encodings for the comparator scheduler and its clients.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } cmp_state_t;

    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;
    localparam logic [1:0] RES_EQ = 2'd3;

    function automatic logic [1:0] res_code(input logic gt, input logic lt);
        return gt ? RES_GT : (lt ? RES_LT : RES_EQ);
    endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit magnitude comparator slice, the shared serial datapath.
// Latency: combinational.  Backpressure: none.
module cmp_bit_slice (
    input  logic a_bit,
    input  logic b_bit,
    output logic gt,
    output logic lt
);
    assign gt = a_bit & ~b_bit;
    assign lt = ~a_bit & b_bit;
endmodule

// File: rtl/rr_arb_nreq.sv
// Round-robin winner select: first set request at or after ptr, wrapping.
// Latency: combinational.  Backpressure: vld low when no request is set.
module rr_arb_nreq
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            vld,
    output logic [IW-1:0]   win
);
    logic [NREQ-1:0] rot;
    logic [IW-1:0]   ofs;
    logic [IW:0]     sum;

    always_comb begin
        // Rotate so that bit 0 is the pointer position; the first set bit is the offset.
        rot = NREQ'({req, req} >> ptr);
        ofs = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) ofs = IW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, ofs};
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        win = sum[IW-1:0];
        vld = |req;
    end
endmodule

// File: rtl/cmp_share_ctrl.sv
// Round-robin share of one bit-serial comparator; MSB-first, one bit per cycle.
// Latency: req sample to done WIDTH+2 (k+2 on mismatch when CMP_EARLY_EXIT_EN is defined).
// Backpressure: req is a level, sampled only in IDLE; others wait for their turn.
module cmp_share_ctrl
    import cmp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    op_a,
    input  logic [NREQ*WIDTH-1:0]    op_b,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     greater,
    output logic                     lesser,
    output logic                     equal
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic              greater_q, greater_d;
    logic              lesser_q, lesser_d;
    logic              equal_q, equal_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              pgt_q, pgt_d;
    logic              plt_q, plt_d;

    logic              arb_vld;
    logic [IW-1:0]     arb_win;
    logic              s_gt, s_lt;
    logic              mis_now;
    logic              cmp_exit;
    logic [WIDTH-1:0]  a_sel, b_sel;

    rr_arb_nreq #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .vld (arb_vld),
        .win (arb_win)
    );

    cmp_bit_slice u_slice (
        .a_bit (sa_q[WIDTH-1]),
        .b_bit (sb_q[WIDTH-1]),
        .gt    (s_gt),
        .lt    (s_lt)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == IW'(i)) begin
                a_sel = op_a[i*WIDTH +: WIDTH];
                b_sel = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign mis_now = mis_q | s_gt | s_lt;

`ifdef CMP_EARLY_EXIT_EN
    assign cmp_exit = (cnt_q == '0) || mis_now;
`else
    assign cmp_exit = (cnt_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        greater_d = greater_q;
        lesser_d  = lesser_q;
        equal_d   = equal_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        pgt_d     = pgt_q;
        plt_d     = plt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_GRANT;
                    gnt_d   = NREQ'(1) << arb_win;
                    busy_d  = 1'b1;
                    win_d   = arb_win;
                end
            end
            ST_GRANT: begin
                state_d = ST_CMP;
                sa_d    = a_sel;
                sb_d    = b_sel;
                cnt_d   = CW'(WIDTH - 1);
                mis_d   = 1'b0;
                pgt_d   = 1'b0;
                plt_d   = 1'b0;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            ST_CMP: begin
                sa_d = sa_q << 1;
                sb_d = sb_q << 1;
                // Only the most significant differing bit decides the result.
                if (!mis_q && (s_gt || s_lt)) begin
                    mis_d = 1'b1;
                    pgt_d = s_gt;
                    plt_d = s_lt;
                end
                if (cmp_exit) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                    greater_d = mis_q ? pgt_q : s_gt;
                    lesser_d  = mis_q ? plt_q : s_lt;
                    equal_d   = ~mis_now;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
            ptr_q     <= '0;
            win_q     <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            mis_q     <= 1'b0;
            pgt_q     <= 1'b0;
            plt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            greater_q <= greater_d;
            lesser_q  <= lesser_d;
            equal_q   <= equal_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            pgt_q     <= pgt_d;
            plt_q     <= plt_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign greater = greater_q;
    assign lesser  = lesser_q;
    assign equal   = equal_q;

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl (NREQ=4, WIDTH=8); latencies follow CMP_EARLY_EXIT_EN.
module tb_cmp_share_ctrl;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   op_a, op_b;
    logic [NREQ-1:0]         gnt;
    logic                    busy, done;
    logic [1:0]              done_id;
    logic                    greater, lesser, equal;

    int checks = 0;
    int errors = 0;

    cmp_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .greater (greater),
        .lesser  (lesser),
        .equal   (equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        int         lat_full;
        int         lat_ee;
        logic       gt;
        logic       lt;
        logic       eq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        op_a = '0;
        op_b = '0;
        op_a[id*WIDTH +: WIDTH] = a;
        op_b[id*WIDTH +: WIDTH] = b;
    endtask

    // Called on a negedge in an IDLE cycle; returns on the negedge after done.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bit seen;
        int exp_lat;
        exp_lat = EE ? v.lat_ee : v.lat_full;
        set_ops(v.id, v.a, v.b);
        req = 4'(1 << v.id);
        @(negedge clk);
        chk({tag, " gnt"}, 32'(gnt), 32'(1 << v.id));
        chk({tag, " busy_at_gnt"}, 32'(busy), 32'd1);
        chk({tag, " done_at_gnt"}, 32'(done), 32'd0);
        req = '0;
        @(negedge clk);
        op_a = ~op_a;
        op_b = ~op_b;
        n = 2;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s done_timeout actual=none required=%0d", tag, exp_lat);
        end else begin
            chk({tag, " latency"}, 32'(n), 32'(exp_lat));
            chk({tag, " done_id"}, 32'(done_id), 32'(v.id));
            chk({tag, " flags"}, {29'd0, greater, lesser, equal}, {29'd0, v.gt, v.lt, v.eq});
            chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
            @(negedge clk);
            chk({tag, " done_pulse"}, 32'(done), 32'd0);
            chk({tag, " hold"}, {27'd0, busy, done_id, greater, lesser, equal},
                {27'd0, 1'b0, 2'(v.id), v.gt, v.lt, v.eq});
        end
    endtask

    task automatic wait_sig(input bit want_gnt, input string tag, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 30) begin
            @(negedge clk);
            n++;
            if (want_gnt ? (|gnt) : done) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s timeout actual=none required=event", tag);
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{0, 8'hA5, 8'hA5, 10, 10, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{2, 8'h80, 8'h7F, 10,  3, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 8'h12, 8'h13, 10, 10, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 8'h00, 8'hFF, 10,  3, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 8'hFF, 8'hFE, 10, 10, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1, 8'hF0, 8'hF8, 10,  7, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2, 8'h00, 8'h00, 10, 10, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{3, 8'h7E, 8'h7C, 10,  9, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        chk("reset outputs", {25'd0, gnt, busy, done, greater, lesser, equal}, 32'd0);
        chk("reset done_id", 32'(done_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {27'd0, gnt, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // All four requesting continuously: pointer is 0 after vec7 (id 3).
        op_a = '0;
        op_b = '0;
        req  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_sig(1'b1, $sformatf("rr%0d gnt", g), ok);
            if (ok) begin
                chk($sformatf("rr%0d gnt", g), 32'(gnt), 32'(1 << (g % 4)));
                if (g == 4) req = '0;
                wait_sig(1'b0, $sformatf("rr%0d done", g), ok);
                if (ok) begin
                    chk($sformatf("rr%0d done_id", g), 32'(done_id), 32'(g % 4));
                    chk($sformatf("rr%0d equal", g), 32'(equal), 32'd1);
                end
            end
        end
        req = '0;
        @(negedge clk);

        // Reset while comparing: everything clears at once, no done pulse follows.
        set_ops(1, 8'h12, 8'h13);
        req = 4'b0010;
        @(negedge clk);
        chk("rst_mid gnt", 32'(gnt), 32'b0010);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid outputs", {25'd0, gnt, busy, done, greater, lesser, equal}, 32'd0);
        chk("rst_mid done_id", 32'(done_id), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst quiet", {30'd0, busy, done}, 32'd0);
        end
        run_vec(vecs[2], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
